bitstream_self_write_sequencer: RTL and testbench

Configuration controller between a byte-wide bitstream source (boot ROM reader, UART/SPI receiver FIFO) and the eFPGA fabric self-write configuration port. It packs bytes into 32-bit big-endian words and paces them onto `SelfWriteData`/`SelfWriteStrobe` with fixed setup and gap cycles. It counts words and, after the final word, holds and then releases a user-design reset so fabric logic starts from a known state.

---
 rtl/bitstream_seq_pkg.sv | 30 +++
 rtl/bitstream_word_packer.sv | 39 +++
 rtl/bitstream_self_write_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bitstream_self_write_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_seq_pkg.sv
// Shared types and constants for the bitstream self-write sequencer.
package bitstream_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SETUP,
    ST_STROBE,
    ST_GAP,
    ST_USER_RST,
    ST_DONE
  } seq_state_t;

  localparam int DEF_BYTES_TOTAL     = 16384;
  localparam int DEF_SETUP_CYCLES    = 2;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int DEF_USER_RST_CYCLES = 5;

  localparam int BYTES_PER_WORD = 4;
  localparam int PHASE_W        = 16;

  // First byte of a word lands in the most significant lane.
  localparam logic BIG_ENDIAN_LANES = 1'b1;

  // Bit offset of the lane that byte number idx (0..3) of a word occupies.
  function automatic int lane_lsb(input logic [1:0] idx);
    return BIG_ENDIAN_LANES ? (3 - int'(idx)) * 8 : int'(idx) * 8;
  endfunction

endpackage

// File: rtl/bitstream_word_packer.sv
// Assembles four accepted bytes into one 32-bit configuration word.
module bitstream_word_packer
  import bitstream_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [31:0] word_reg;
  logic [1:0]  idx_reg;

  // Partial word with the byte currently on the input merged into its lane.
  always_comb begin
    word = word_reg;
    word[lane_lsb(idx_reg) +: 8] = byte_data;
  end

  assign word_done = accept && (idx_reg == 2'd3);

  // Byte index and partial word; a clear drops any half-assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (clear) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (accept) begin
      word_reg <= word;
      idx_reg  <= idx_reg + 2'd1;
    end
  end

endmodule

// File: rtl/bitstream_self_write_sequencer.sv
// Paces packed bitstream words onto the fabric self-write port, then
// holds and releases the user-design reset.
module bitstream_self_write_sequencer
  import bitstream_seq_pkg::*;
#(
  parameter int BYTES_TOTAL     = DEF_BYTES_TOTAL,
  parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int USER_RST_CYCLES = DEF_USER_RST_CYCLES,
  localparam int WCW            = $clog2(BYTES_TOTAL / 4 + 1)
) (
  input  logic           CLK,
  input  logic           resetn,
  input  logic           start,
  input  logic           abort,
  input  logic [7:0]     byte_data,
  input  logic           byte_valid,
  output logic           byte_ready,
  output logic [31:0]    SelfWriteData,
  output logic           SelfWriteStrobe,
  output logic           busy,
  output logic           done,
  output logic [WCW-1:0] word_count,
  output logic           user_reset
);

  localparam logic [WCW-1:0]     WORDS_TOTAL = WCW'(BYTES_TOTAL / BYTES_PER_WORD);
  localparam logic [PHASE_W-1:0] SETUP_LAST  = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST    = PHASE_W'(GAP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] URST_LAST   = PHASE_W'(USER_RST_CYCLES - 1);

  seq_state_t         state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic [WCW-1:0]     wc_reg, wc_next;
  logic [31:0]        data_reg, data_next;
  logic               ures_reg, ures_next;
  logic               done_reg, done_next;

  logic        idle_like;
  logic        start_load;
  logic        abort_load;
  logic        accept;
  logic [31:0] pack_word;
  logic        pack_done;

  assign idle_like  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign start_load = idle_like && start;
  assign abort_load = !idle_like && abort;
  assign accept     = (state_reg == ST_COLLECT) && byte_valid;

  bitstream_word_packer u_packer (
    .clk       (CLK),
    .rst_n     (resetn),
    .clear     (start_load || abort_load),
    .accept    (accept),
    .byte_data (byte_data),
    .word      (pack_word),
    .word_done (pack_done)
  );

  // State, phase counter, word counter and output registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      wc_reg    <= '0;
      data_reg  <= '0;
      ures_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      wc_reg    <= wc_next;
      data_reg  <= data_next;
      ures_reg  <= ures_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and next-register decode; abort overrides every transition.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    wc_next    = wc_reg;
    data_next  = data_reg;
    ures_next  = ures_reg;
    done_next  = done_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_COLLECT;
          wc_next    = '0;
          ures_next  = 1'b1;
          done_next  = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (pack_done) begin
          data_next  = pack_word;
          phase_next = '0;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_reg == SETUP_LAST) begin
          state_next = ST_STROBE;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      ST_STROBE: begin
        wc_next    = wc_reg + WCW'(1);
        phase_next = '0;
        if (GAP_CYCLES != 0) begin
          state_next = ST_GAP;
        end else if (wc_next == WORDS_TOTAL) begin
          state_next = ST_USER_RST;
        end else begin
          state_next = ST_COLLECT;
        end
      end
      ST_GAP: begin
        if (phase_reg == GAP_LAST) begin
          phase_next = '0;
          state_next = (wc_reg == WORDS_TOTAL) ? ST_USER_RST : ST_COLLECT;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      ST_USER_RST: begin
        if (phase_reg == URST_LAST) begin
          ures_next  = 1'b0;
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A cancelled load keeps its word count, data and reset/done levels.
    if (abort_load) begin
      state_next = ST_IDLE;
      phase_next = '0;
      wc_next    = wc_reg;
      data_next  = data_reg;
      ures_next  = ures_reg;
      done_next  = done_reg;
    end
  end

  assign byte_ready      = (state_reg == ST_COLLECT);
  assign SelfWriteStrobe = (state_reg == ST_STROBE);
  assign busy            = !idle_like;
  assign SelfWriteData   = data_reg;
  assign word_count      = wc_reg;
  assign user_reset      = ures_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_bitstream_self_write_sequencer.sv
// Scoreboard bench: expected words are queued as bytes are accepted and
// matched against each strobe from either sequencer instance.
module tb_bitstream_self_write_sequencer;

  typedef struct {
    int          dut;
    logic [31:0] word;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i [2];
  logic        abort_i [2];
  logic [7:0]  data_i [2];
  logic        valid_i [2];
  logic        ready_o [2];
  logic [31:0] sw_data [2];
  logic        strobe_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        ures_o [2];
  logic [12:0] wc_a;
  logic [1:0]  wc_b;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   first_strobe = -1;
  int   last_strobe = -1;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  bitstream_self_write_sequencer u_dut_a (
    .CLK             (CLK),
    .resetn          (resetn),
    .start           (start_i[0]),
    .abort           (abort_i[0]),
    .byte_data       (data_i[0]),
    .byte_valid      (valid_i[0]),
    .byte_ready      (ready_o[0]),
    .SelfWriteData   (sw_data[0]),
    .SelfWriteStrobe (strobe_o[0]),
    .busy            (busy_o[0]),
    .done            (done_o[0]),
    .word_count      (wc_a),
    .user_reset      (ures_o[0])
  );

  bitstream_self_write_sequencer #(
    .BYTES_TOTAL     (8),
    .SETUP_CYCLES    (1),
    .GAP_CYCLES      (0),
    .USER_RST_CYCLES (5)
  ) u_dut_b (
    .CLK             (CLK),
    .resetn          (resetn),
    .start           (start_i[1]),
    .abort           (abort_i[1]),
    .byte_data       (data_i[1]),
    .byte_valid      (valid_i[1]),
    .byte_ready      (ready_o[1]),
    .SelfWriteData   (sw_data[1]),
    .SelfWriteStrobe (strobe_o[1]),
    .busy            (busy_o[1]),
    .done            (done_o[1]),
    .word_count      (wc_b),
    .user_reset      (ures_o[1])
  );

  function automatic int setup_of(input int d); return (d != 0) ? 1 : 2; endfunction
  function automatic int gap_of(input int d);   return (d != 0) ? 0 : 2; endfunction
  function automatic int words_of(input int d); return (d != 0) ? 2 : 4096; endfunction
  function automatic int wc_of(input int d);    return (d != 0) ? int'(wc_b) : int'(wc_a); endfunction

  // Word w of a source that emits bytes 00,01,02,... (wrapping at 256).
  function automatic logic [31:0] mk_word(input int w);
    int b;
    b = 4 * w;
    return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe monitor: every strobe must match the oldest queued word and cycle.
  always @(negedge CLK) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (resetn && strobe_o[d]) begin
        check("strobe_pending", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("strobe_dut", 64'(d), 64'(e.dut));
          check("strobe_data", 64'(sw_data[d]), 64'(e.word));
          check("strobe_cycle", 64'(cyc), 64'(e.cyc));
        end
        last_strobe = cyc;
        if (first_strobe < 0) first_strobe = cyc;
      end
    end
  end

  task automatic check_reset_vals(input int d);
    check("rst_strobe", 64'(strobe_o[d]), 64'(0));
    check("rst_data", 64'(sw_data[d]), 64'(0));
    check("rst_ready", 64'(ready_o[d]), 64'(0));
    check("rst_busy", 64'(busy_o[d]), 64'(0));
    check("rst_done", 64'(done_o[d]), 64'(0));
    check("rst_wc", 64'(wc_of(d)), 64'(0));
    check("rst_ures", 64'(ures_o[d]), 64'(1));
  endtask

  task automatic start_load(input int d);
    @(negedge CLK);
    start_i[d] = 1'b1;
    first_strobe = -1;
    @(negedge CLK);
    start_i[d] = 1'b0;
    $display("start dut%0d: busy=%0d done=%0d wc=%0d ures=%0d", d, busy_o[d], done_o[d], wc_of(d), ures_o[d]);
    check("start_busy", 64'(busy_o[d]), 64'(1));
    check("start_done", 64'(done_o[d]), 64'(0));
    check("start_wc", 64'(wc_of(d)), 64'(0));
    check("start_ures", 64'(ures_o[d]), 64'(1));
  endtask

  // Feeds one load; optional stall, stray start pulses, abort or reset.
  task automatic run_load(input int d, input int stall_word, input int stall_len,
                          input int abort_word, input int rst_word, input bit poke_start);
    int   nbytes = 0;
    int   stalls = 0;
    int   nstrobe = 0;
    bit   acc = 0;
    bit   pushed;
    bit   prev_strobe = 0;
    bit   fin = 0;
    exp_t e;
    for (int g = 0; g < 40000; g++) begin
      @(negedge CLK);
      pushed = 0;
      if (acc) begin
        nbytes++;
        if (nbytes % 4 == 0) begin
          e.dut  = d;
          e.word = mk_word(nbytes / 4 - 1);
          e.cyc  = cyc + setup_of(d);
          sb.push_back(e);
          pushed = 1;
        end
      end
      if (strobe_o[d]) nstrobe++;
      if (done_o[d]) begin
        fin = 1;
        break;
      end
      if (abort_word >= 0 && pushed && nbytes == 4 * (abort_word + 1)) begin
        valid_i[d] = 1'b0;
        abort_i[d] = 1'b1;
        e = sb.pop_back();
        @(negedge CLK);
        abort_i[d] = 1'b0;
        $display("abort dut%0d: busy=%0d wc=%0d ures=%0d done=%0d", d, busy_o[d], wc_of(d), ures_o[d], done_o[d]);
        check("abort_busy", 64'(busy_o[d]), 64'(0));
        check("abort_strobe", 64'(strobe_o[d]), 64'(0));
        check("abort_wc", 64'(wc_of(d)), 64'(abort_word));
        check("abort_ures", 64'(ures_o[d]), 64'(1));
        check("abort_done", 64'(done_o[d]), 64'(0));
        check("abort_data", 64'(sw_data[d]), 64'(e.word));
        repeat (3) @(negedge CLK);
        check("abort_idle", 64'(busy_o[d]), 64'(0));
        return;
      end
      if (rst_word >= 0 && strobe_o[d] && nstrobe == rst_word + 1) begin
        valid_i[d] = 1'b0;
        #2 resetn = 1'b0;
        #1;
        $display("reset mid-strobe dut%0d: strobe=%0d busy=%0d", d, strobe_o[d], busy_o[d]);
        check_reset_vals(0);
        check_reset_vals(1);
        sb.delete();
        @(negedge CLK);
        resetn = 1'b1;
        return;
      end
      start_i[d] = poke_start && ((nbytes == 20 && ready_o[d]) || (prev_strobe && nstrobe == 3));
      if (stall_word >= 0 && nbytes == 4 * stall_word + 2 && stalls < stall_len && ready_o[d]) begin
        valid_i[d] = 1'b0;
        stalls++;
      end else begin
        valid_i[d] = 1'b1;
      end
      data_i[d]   = nbytes[7:0];
      acc         = valid_i[d] && ready_o[d];
      prev_strobe = strobe_o[d];
    end
    valid_i[d] = 1'b0;
    start_i[d] = 1'b0;
    $display("load dut%0d end: fin=%0d wc=%0d ures=%0d strobes=%0d", d, fin, wc_of(d), ures_o[d], nstrobe);
    check("load_finished", 64'(fin), 64'(1));
    if (fin) begin
      check("done_wc", 64'(wc_of(d)), 64'(words_of(d)));
      check("done_ures", 64'(ures_o[d]), 64'(0));
      check("done_busy", 64'(busy_o[d]), 64'(0));
      check("done_strobes", 64'(nstrobe), 64'(words_of(d)));
      check("done_data", 64'(sw_data[d]), 64'(mk_word(words_of(d) - 1)));
      check("done_sb_empty", 64'(sb.size()), 64'(0));
      check("done_timing", 64'(cyc), 64'(last_strobe + 1 + gap_of(d) + 5));
      check("strobe_span", 64'(last_strobe - first_strobe),
            64'((words_of(d) - 1) * (5 + setup_of(d) + gap_of(d)) + ((stall_word >= 0) ? stall_len : 0)));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0;
      abort_i[d] = 1'b0;
      data_i[d]  = 8'h00;
      valid_i[d] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    check_reset_vals(0);
    check_reset_vals(1);
    resetn = 1'b1;
    @(negedge CLK);
    check_reset_vals(0);

    start_load(0);
    run_load(0, 5, 7, -1, -1, 1'b1);

    start_load(0);
    run_load(0, -1, 0, 9, -1, 1'b0);

    start_load(0);
    run_load(0, -1, 0, -1, 3, 1'b0);

    start_load(0);
    run_load(0, -1, 0, -1, -1, 1'b0);

    start_load(1);
    run_load(1, -1, 0, -1, -1, 1'b0);
    start_load(1);
    run_load(1, -1, 0, -1, -1, 1'b0);

    repeat (4) @(negedge CLK);
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
